// File: rtl/font_rom.sv
// ---------------------------------------------------------------------------
// font_rom -- character generator ROM for the 640x480 text display.
//
// Maps an 8-bit character code to a 6x12 monochrome glyph. The glyph is
// flattened to 72 bits, with bit index = row*6 + col. Row 0 is the top row
// and col 0 is the leftmost column. A 1 is a lit pixel.
//
// Ports:
//   clk        in   rising-edge pixel clock
//   rst_n      in   asynchronous active-low reset; blanks the output at once
//   fr_ch_code in   [7:0]  character code to look up
//   fr_glyph   out  [71:0] registered glyph for the code sampled on the
//                          previous clock edge
//
// Interface: there is no handshake. A new code is accepted on every rising
// edge, and its glyph appears exactly one cycle later. No enable exists.
//
// Printable glyphs (0x20..0x7E) come from a 5x7 column-coded font. That font
// is stretched vertically to 11 rows by repeating font rows 0, 2, 4 and 6.
// Col 5 and row 11 stay clear, which gives the spacing between characters.
// ---------------------------------------------------------------------------
module font_rom #(
    parameter int CH_WIDTH   = 6,
    parameter int CH_HEIGHT  = 12,
    parameter int GLYPH_BITS = CH_WIDTH * CH_HEIGHT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            fr_ch_code,
    output logic [GLYPH_BITS-1:0] fr_glyph
);

    // 5x7 font, five column bytes per code. Col 0 is in bits [39:32], and
    // bit i of a column byte is font row i (top = 0).
    function automatic logic [39:0] font_cols(input logic [7:0] code);
        case (code)
            8'h21: font_cols = 40'h00_00_5F_00_00;
            8'h22: font_cols = 40'h00_07_00_07_00;
            8'h23: font_cols = 40'h14_7F_14_7F_14;
            8'h24: font_cols = 40'h24_2A_7F_2A_12;
            8'h25: font_cols = 40'h23_13_08_64_62;
            8'h26: font_cols = 40'h36_49_56_20_50;
            8'h27: font_cols = 40'h00_05_03_00_00;
            8'h28: font_cols = 40'h00_1C_22_41_00;
            8'h29: font_cols = 40'h00_41_22_1C_00;
            8'h2A: font_cols = 40'h2A_1C_7F_1C_2A;
            8'h2B: font_cols = 40'h08_08_3E_08_08;
            8'h2C: font_cols = 40'h00_50_30_00_00;
            8'h2D: font_cols = 40'h08_08_08_08_08;
            8'h2E: font_cols = 40'h00_60_60_00_00;
            8'h2F: font_cols = 40'h20_10_08_04_02;
            8'h30: font_cols = 40'h3E_51_49_45_3E;
            8'h31: font_cols = 40'h00_42_7F_40_00;
            8'h32: font_cols = 40'h42_61_51_49_46;
            8'h33: font_cols = 40'h21_41_45_4B_31;
            8'h34: font_cols = 40'h18_14_12_7F_10;
            8'h35: font_cols = 40'h27_45_45_45_39;
            8'h36: font_cols = 40'h3C_4A_49_49_30;
            8'h37: font_cols = 40'h01_71_09_05_03;
            8'h38: font_cols = 40'h36_49_49_49_36;
            8'h39: font_cols = 40'h06_49_49_29_1E;
            8'h3A: font_cols = 40'h00_36_36_00_00;
            8'h3B: font_cols = 40'h00_56_36_00_00;
            8'h3C: font_cols = 40'h08_14_22_41_00;
            8'h3D: font_cols = 40'h14_14_14_14_14;
            8'h3E: font_cols = 40'h00_41_22_14_08;
            8'h3F: font_cols = 40'h02_01_51_09_06;
            8'h40: font_cols = 40'h32_49_79_41_3E;
            8'h41: font_cols = 40'h7E_11_11_11_7E;
            8'h42: font_cols = 40'h7F_49_49_49_36;
            8'h43: font_cols = 40'h3E_41_41_41_22;
            8'h44: font_cols = 40'h7F_41_41_22_1C;
            8'h45: font_cols = 40'h7F_49_49_49_41;
            8'h46: font_cols = 40'h7F_09_09_09_01;
            8'h47: font_cols = 40'h3E_41_49_49_7A;
            8'h48: font_cols = 40'h7F_08_08_08_7F;
            8'h49: font_cols = 40'h00_41_7F_41_00;
            8'h4A: font_cols = 40'h20_40_41_3F_01;
            8'h4B: font_cols = 40'h7F_08_14_22_41;
            8'h4C: font_cols = 40'h7F_40_40_40_40;
            8'h4D: font_cols = 40'h7F_02_0C_02_7F;
            8'h4E: font_cols = 40'h7F_04_08_10_7F;
            8'h4F: font_cols = 40'h3E_41_41_41_3E;
            8'h50: font_cols = 40'h7F_09_09_09_06;
            8'h51: font_cols = 40'h3E_41_51_21_5E;
            8'h52: font_cols = 40'h7F_09_19_29_46;
            8'h53: font_cols = 40'h46_49_49_49_31;
            8'h54: font_cols = 40'h01_01_7F_01_01;
            8'h55: font_cols = 40'h3F_40_40_40_3F;
            8'h56: font_cols = 40'h1F_20_40_20_1F;
            8'h57: font_cols = 40'h3F_40_38_40_3F;
            8'h58: font_cols = 40'h63_14_08_14_63;
            8'h59: font_cols = 40'h07_08_70_08_07;
            8'h5A: font_cols = 40'h61_51_49_45_43;
            8'h5B: font_cols = 40'h00_7F_41_41_00;
            8'h5C: font_cols = 40'h02_04_08_10_20;
            8'h5D: font_cols = 40'h00_41_41_7F_00;
            8'h5E: font_cols = 40'h04_02_01_02_04;
            8'h5F: font_cols = 40'h40_40_40_40_40;
            8'h60: font_cols = 40'h00_01_02_04_00;
            8'h61: font_cols = 40'h20_54_54_54_78;
            8'h62: font_cols = 40'h7F_48_44_44_38;
            8'h63: font_cols = 40'h38_44_44_44_20;
            8'h64: font_cols = 40'h38_44_44_48_7F;
            8'h65: font_cols = 40'h38_54_54_54_18;
            8'h66: font_cols = 40'h08_7E_09_01_02;
            8'h67: font_cols = 40'h0C_52_52_52_3E;
            8'h68: font_cols = 40'h7F_08_04_04_78;
            8'h69: font_cols = 40'h00_44_7D_40_00;
            8'h6A: font_cols = 40'h20_40_44_3D_00;
            8'h6B: font_cols = 40'h7F_10_28_44_00;
            8'h6C: font_cols = 40'h00_41_7F_40_00;
            8'h6D: font_cols = 40'h7C_04_18_04_78;
            8'h6E: font_cols = 40'h7C_08_04_04_78;
            8'h6F: font_cols = 40'h38_44_44_44_38;
            8'h70: font_cols = 40'h7C_14_14_14_08;
            8'h71: font_cols = 40'h08_14_14_18_7C;
            8'h72: font_cols = 40'h7C_08_04_04_08;
            8'h73: font_cols = 40'h48_54_54_54_20;
            8'h74: font_cols = 40'h04_3F_44_40_20;
            8'h75: font_cols = 40'h3C_40_40_20_7C;
            8'h76: font_cols = 40'h1C_20_40_20_1C;
            8'h77: font_cols = 40'h3C_40_30_40_3C;
            8'h78: font_cols = 40'h44_28_10_28_44;
            8'h79: font_cols = 40'h0C_50_50_50_3C;
            8'h7A: font_cols = 40'h44_64_54_4C_44;
            8'h7B: font_cols = 40'h00_08_36_41_00;
            8'h7C: font_cols = 40'h00_00_7F_00_00;
            8'h7D: font_cols = 40'h00_41_36_08_00;
            8'h7E: font_cols = 40'h10_08_08_10_08;
            default: font_cols = 40'h00_00_00_00_00; // includes space
        endcase
    endfunction

    // Maps a glyph row (0..10) to the 5x7 font row it repeats. Rows 0, 2, 4
    // and 6 of the font are doubled, so the 7 font rows fill 11 glyph rows.
    // With this map the '-' bar (font row 3) lands on glyph row 5, and
    // lowercase bodies (font rows 2..6) fill glyph rows 3..10.
    function automatic int src_row(input int r);
        case (r)
            0, 1:    src_row = 0;
            2:       src_row = 1;
            3, 4:    src_row = 2;
            5:       src_row = 3;
            6, 7:    src_row = 4;
            8:       src_row = 5;
            default: src_row = 6;
        endcase
    endfunction

    logic [39:0]           cols;
    logic [GLYPH_BITS-1:0] rom_glyph;

    always_comb begin
        cols      = font_cols(fr_ch_code);
        rom_glyph = '0;
        if (fr_ch_code == 8'hFF) begin
            rom_glyph = '1;
        end else if (fr_ch_code == 8'hFE) begin
            for (int r = 0; r < CH_HEIGHT; r++)
                for (int c = 0; c < CH_WIDTH; c++)
                    rom_glyph[r*CH_WIDTH + c] = ((r + c) % 2 == 0);
        end else if (fr_ch_code >= 8'h20 && fr_ch_code <= 8'h7E) begin
            if (fr_ch_code == 8'h5F) begin
                // The stretch doubles the font's bottom row. The underscore
                // must sit on row 10 only.
                rom_glyph[10*CH_WIDTH +: 5] = 5'h1F;
            end else begin
                for (int r = 0; r < CH_HEIGHT - 1; r++)
                    for (int c = 0; c < CH_WIDTH - 1; c++)
                        rom_glyph[r*CH_WIDTH + c] = cols[(4 - c)*8 + src_row(r)];
            end
        end else begin
            // Unknown code: a hollow box marks it on screen.
            for (int r = 0; r < CH_HEIGHT; r++)
                for (int c = 0; c < CH_WIDTH; c++)
                    rom_glyph[r*CH_WIDTH + c] = (r == 0) || (r == CH_HEIGHT - 1) ||
                                                (c == 0) || (c == CH_WIDTH - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fr_glyph <= '0;
        else        fr_glyph <= rom_glyph;
    end

endmodule

// File: tb/tb_font_rom.sv
// ---------------------------------------------------------------------------
// tb_font_rom -- self-checking bench for font_rom.
// The driver issues one code per cycle and pushes the expected response.
// A monitor pops one entry per clock edge, while reset is released, and
// checks it against the glyph.
// ---------------------------------------------------------------------------
module tb_font_rom;

    localparam int W = 72;

    localparam logic [1:0] K_EXACT   = 2'd0; // full 72-bit compare
    localparam logic [1:0] K_SPACING = 2'd1; // col 5 and row 11 must be blank

    typedef struct packed {
        logic [1:0]   kind;
        logic [7:0]   code;
        logic [W-1:0] glyph;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   fr_ch_code;
    logic [W-1:0] fr_glyph;

    sb_t          exp_q[$];
    sb_t          mon_e;
    logic [W-1:0] seen_upper_a;
    logic [W-1:0] seen_lower_a;
    int           checks = 0;
    int           errors = 0;

    font_rom dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fr_ch_code(fr_ch_code),
        .fr_glyph  (fr_glyph)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- expected-value helpers ----------------
    function automatic logic [W-1:0] box_glyph();
        logic [W-1:0] g;
        g = '0;
        g[5:0]   = 6'h3F;
        g[71:66] = 6'h3F;
        for (int r = 1; r <= 10; r++) begin
            g[6*r]     = 1'b1;
            g[6*r + 5] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [W-1:0] checker_glyph();
        logic [W-1:0] g;
        for (int k = 0; k < W; k++) g[k] = (((k / 6) + (k % 6)) % 2 == 0);
        return g;
    endfunction

    function automatic logic [W-1:0] bar_glyph();
        logic [W-1:0] g;
        g = '0;
        for (int r = 0; r <= 10; r++) g[6*r + 2] = 1'b1;
        return g;
    endfunction

    // Uppercase 'A' drawn row by row (bit 0 = leftmost pixel):
    //  .XXX.  .XXX.  X...X  X...X  X...X  X...X  XXXXX  XXXXX  X...X x3  blank
    function automatic logic [W-1:0] upper_a_glyph();
        logic [W-1:0] g;
        logic [5:0]   rows [12];
        rows = '{6'h0E, 6'h0E, 6'h11, 6'h11, 6'h11, 6'h11,
                 6'h1F, 6'h1F, 6'h11, 6'h11, 6'h11, 6'h00};
        for (int r = 0; r < 12; r++) g[6*r +: 6] = rows[r];
        return g;
    endfunction

    task automatic check72(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [7:0] code, input logic [1:0] kind, input logic [W-1:0] exp);
        sb_t e;
        @(negedge clk);
        fr_ch_code = code;
        e.kind  = kind;
        e.code  = code;
        e.glyph = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.code == 8'h41) seen_upper_a = fr_glyph;
            if (mon_e.code == 8'h61) seen_lower_a = fr_glyph;
            if (mon_e.kind == K_EXACT) begin
                check72($sformatf("glyph_%02h", mon_e.code), fr_glyph, mon_e.glyph);
            end else begin
                checks++;
                if (fr_glyph[71:66] !== 6'h00 ||
                    (fr_glyph & {12{6'b100000}}) !== '0) begin
                    errors++;
                    $display("FAIL spacing_%02h: got %h expected col5/row11 clear",
                             mon_e.code, fr_glyph);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] unk [5];
        unk = '{8'h00, 8'h1F, 8'h7F, 8'h80, 8'hFD};
        seen_upper_a = '0;
        seen_lower_a = '0;

        // 1: reset held with the clock running, then release
        rst_n      = 1'b0;
        fr_ch_code = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check72("reset_hold", fr_glyph, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'hFF, K_EXACT, '1);

        // 2: back-to-back special printables
        issue(8'h20, K_EXACT, '0);
        issue(8'h2D, K_EXACT, {{(W-5){1'b0}}, 5'h1F} << 30);
        issue(8'h5F, K_EXACT, {{(W-5){1'b0}}, 5'h1F} << 60);

        // 3: unknown codes give the hollow box
        for (int i = 0; i < 5; i++) issue(unk[i], K_EXACT, box_glyph());

        // 4: checkerboard
        issue(8'hFE, K_EXACT, checker_glyph());

        // Directed glyphs
        issue(8'h7C, K_EXACT, bar_glyph());
        issue(8'h41, K_EXACT, upper_a_glyph());
        issue(8'hFF, K_EXACT, '1);
        issue(8'hFF, K_EXACT, '1);
        drain();

        // 5: sweep the printables for inter-character spacing
        for (int k = 8'h21; k <= 8'h7E; k++) issue(k[7:0], K_SPACING, '0);
        drain();
        checks++;
        if (seen_upper_a === '0 || seen_upper_a === seen_lower_a) begin
            errors++;
            $display("FAIL a_vs_A: 'A'=%h 'a'=%h, expected non-zero and different",
                     seen_upper_a, seen_lower_a);
        end

        // 6: asynchronous reset mid-stream
        issue(8'hFF, K_EXACT, '1);
        issue(8'hFF, K_EXACT, '1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check72("async_reset", fr_glyph, '0);
        @(posedge clk);
        #1;
        check72("reset_held_edge", fr_glyph, '0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h2D, K_EXACT, {{(W-5){1'b0}}, 5'h1F} << 30);
        issue(8'hFF, K_EXACT, '1);
        issue(8'h20, K_EXACT, '0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
